flag_branch_unit: RTL
=====================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 20'h00000, meaning the PC value loaded on reset.
REQ-002 The module SHALL have parameter TRAP_VEC, default 20'hFFF00, meaning the PC value loaded on TRAP.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flag_valid  input  1  ALU result flags valid this cycle.
REQ-006 flag_zero, flag_sign, flag_carry  input  1 each  ALU zero, sign and carry flags.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-009 cmd_op  input  3  opcode: 0 NOP, 1 JMP, 2 JZ, 3 JS, 4 JZS, 5 LDSR, 6 XORSR, 7 TRAP.
REQ-010 cmd_target  input  20  jump target.
REQ-011 cmd_imm  input  3  status operand {C,S,Z}.
REQ-012 trap_clr  input  1  request to leave trap mode.
REQ-013 pc  output  20  registered program counter.
REQ-014 pc_load  output  1  one-cycle pulse on every PC commit.
REQ-015 sr  output  4  registered status {T,C,S,Z}.
REQ-016 trap_mode  output  1  equals sr[3].

Function
REQ-017 FSM states SHALL be IDLE, EXEC and TRAP; cmd_ready SHALL be 1 only in IDLE.
REQ-018 Accept at edge E SHALL latch op/target/imm and move IDLE->EXEC; the edge E+1 SHALL commit and move EXEC->IDLE (TRAP for op 7), giving throughput of 1 command per 2 cycles.
REQ-019 Each commit SHALL set pc and pulse pc_load high for exactly the cycle after E+1; pc_load SHALL be 0 at all other times.
REQ-020 NOP, LDSR, XORSR and untaken jumps SHALL set pc to pc+1, modulo 2^20 (20'hFFFFF wraps to 20'h00000).
REQ-021 JMP SHALL always be taken; JZ SHALL be taken if Z=1; JS if S=1; JZS if Z=1 or S=1; a taken jump SHALL set pc to the latched target.
REQ-022 Jump conditions SHALL use the registered sr value during the EXEC cycle; flag_valid in that same cycle SHALL NOT affect the decision.
REQ-023 LDSR SHALL set {C,S,Z} to imm; XORSR SHALL set {C,S,Z} to {C,S,Z} XOR imm; neither SHALL change T.
REQ-024 With flag_valid high at an edge, sr[2:0] SHALL capture {carry,sign,zero}, in all states.
REQ-025 If LDSR or XORSR commits on the same edge as flag_valid, the command result SHALL win.
REQ-026 TRAP SHALL set T=1, set pc to TRAP_VEC, pulse pc_load and enter TRAP.
REQ-027 In TRAP, trap_clr high at an edge SHALL clear T and return to IDLE without changing pc.
REQ-028 trap_clr outside TRAP SHALL be ignored.
REQ-029 Commands offered while cmd_ready is 0 SHALL be held by the sender and SHALL NOT be dropped or double-accepted.

Reset
REQ-030 While rst_n=0 the module SHALL force: pc=RESET_PC, sr=4'b0000, pc_load=0, state IDLE (cmd_ready=1), trap_mode=0.
REQ-031 Reset assertion in EXEC or TRAP SHALL abandon the latched command with no commit.
REQ-032 The first command SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-033 Opcode encodings, SR bit indices (Z=0, S=1, C=2, T=3) and WORD_W=20 SHALL live in a shared cpu package used by the ALU and the decoder.
REQ-034 A combinational sub-module branch_cond SHALL take the opcode and sr and produce the taken output.
REQ-035 The FSM, PC and SR registers SHALL remain in flag_branch_unit.

Verification
REQ-036 After reset, issue JMP with target 20'h00ABC -> pc=20'h00ABC, one pc_load pulse, cmd_ready low for exactly 1 cycle.
REQ-037 flag_valid with zero=1, then JZ with target 20'h00100 -> taken; then LDSR imm=0 followed by JZ -> pc increments by 1.
REQ-038 pc=20'hFFFFF, issue NOP -> pc=20'h00000.
REQ-039 XORSR imm=3'b101 on the same edge as flag_valid {C,S,Z}=000 -> sr=4'b0101.
REQ-040 TRAP -> pc=20'hFFF00, trap_mode=1, cmd_ready held 0 for 5 cycles; trap_clr -> sr[3]=0, IDLE, pc unchanged.
REQ-041 Assert rst_n low during EXEC of a JMP -> pc=RESET_PC, no pc_load pulse, and the next command after reset is accepted normally.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// Shared cpu definitions: word width, status-register bit positions and command opcodes.
package flag_branch_unit_pkg;

    localparam int unsigned WORD_W = 20;
    localparam int unsigned IMM_W  = 3;
    localparam int unsigned SR_W   = 4;

    localparam int unsigned SR_Z = 0;
    localparam int unsigned SR_S = 1;
    localparam int unsigned SR_C = 2;
    localparam int unsigned SR_T = 3;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_JMP   = 3'd1,
        OP_JZ    = 3'd2,
        OP_JS    = 3'd3,
        OP_JZS   = 3'd4,
        OP_LDSR  = 3'd5,
        OP_XORSR = 3'd6,
        OP_TRAP  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    // Command captured at acceptance and consumed at commit.
    typedef struct packed {
        op_t               op;
        logic [WORD_W-1:0] target;
        logic [IMM_W-1:0]  imm;
    } cmd_t;

endpackage

// File: rtl/flag_branch_unit_branch_cond.sv
// Jump decision from the opcode and the Z/S status bits.
module branch_cond
    import flag_branch_unit_pkg::*;
(
    input  op_t              op,
    input  logic [SR_S:SR_Z] sr,
    output logic             taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = sr[SR_Z];
            OP_JS:   taken = sr[SR_S];
            OP_JZS:  taken = sr[SR_Z] | sr[SR_S];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Two-cycle command unit: accepts a jump/status/trap command, commits it to pc/sr on the next edge.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 20'h00000,
    parameter logic [WORD_W-1:0] TRAP_VEC = 20'hFFF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_valid,
    input  logic              flag_zero,
    input  logic              flag_sign,
    input  logic              flag_carry,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WORD_W-1:0] cmd_target,
    input  logic [IMM_W-1:0]  cmd_imm,
    input  logic              trap_clr,
    output logic [WORD_W-1:0] pc,
    output logic              pc_load,
    output logic [SR_W-1:0]   sr,
    output logic              trap_mode
);

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              pc_load_q, pc_load_d;
    logic              taken;

    branch_cond u_branch_cond (
        .op    (cmd_q.op),
        .sr    (sr_q[SR_S:SR_Z]),
        .taken (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            pc_q      <= RESET_PC;
            sr_q      <= '0;
            pc_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            pc_q      <= pc_d;
            sr_q      <= sr_d;
            pc_load_q <= pc_load_d;
        end
    end

    // Flag capture is applied first so a committing status command overrides it.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        pc_d      = pc_q;
        sr_d      = sr_q;
        pc_load_d = 1'b0;

        if (flag_valid) begin
            sr_d[SR_C:SR_Z] = {flag_carry, flag_sign, flag_zero};
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.op     = op_t'(cmd_op);
                    cmd_d.target = cmd_target;
                    cmd_d.imm    = cmd_imm;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_load_d = 1'b1;
                state_d   = ST_IDLE;
                pc_d      = taken ? cmd_q.target : pc_q + WORD_W'(1);
                case (cmd_q.op)
                    OP_LDSR:  sr_d[SR_C:SR_Z] = cmd_q.imm;
                    OP_XORSR: sr_d[SR_C:SR_Z] = sr_q[SR_C:SR_Z] ^ cmd_q.imm;
                    OP_TRAP: begin
                        sr_d[SR_T] = 1'b1;
                        pc_d       = TRAP_VEC;
                        state_d    = ST_TRAP;
                    end
                    default: ;
                endcase
            end
            ST_TRAP: begin
                if (trap_clr) begin
                    sr_d[SR_T] = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign pc        = pc_q;
    assign pc_load   = pc_load_q;
    assign sr        = sr_q;
    assign trap_mode = sr_q[SR_T];

endmodule
